// File: rtl/host_cmd_link_pkg.sv
// ---------------------------------------------------------------------------
// host_link_pkg
// Shared types and constants for the host command link: the RX/TX UART
// state encodings and the command geometry (3 bytes of 8 bits, MSB byte
// first on the wire).
// ---------------------------------------------------------------------------
package host_link_pkg;

    localparam int CMD_BYTES = 3;
    localparam int DATA_BITS = 8;
    localparam int CMD_W     = CMD_BYTES * DATA_BITS;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/host_cmd_link_if.sv
// ---------------------------------------------------------------------------
// host_cmd_link_if
// Core-side command/response bundle of the host link.
//   cmd/cmd_rdy/clr_cmd_rdy : assembled 24-bit command, held until cleared
//   resp_data/send_resp     : response byte and its one-cycle send request
//   resp_sent               : one-cycle pulse when the response stop bit ends
//   frm_err/ovr_err         : one-cycle error pulses from the receive side
// master = the digital core, slave = host_cmd_link.
// ---------------------------------------------------------------------------
interface host_cmd_link_if;
    import host_link_pkg::*;

    logic [CMD_W-1:0]     cmd;
    logic                 cmd_rdy;
    logic                 clr_cmd_rdy;
    logic [DATA_BITS-1:0] resp_data;
    logic                 send_resp;
    logic                 resp_sent;
    logic                 frm_err;
    logic                 ovr_err;

    modport master (
        input  cmd, cmd_rdy, resp_sent, frm_err, ovr_err,
        output clr_cmd_rdy, resp_data, send_resp
    );

    modport slave (
        output cmd, cmd_rdy, resp_sent, frm_err, ovr_err,
        input  clr_cmd_rdy, resp_data, send_resp
    );

endinterface

// File: rtl/host_cmd_link_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
// 8N1 LSB-first UART byte receiver.
//   clk, rst_n : system clock, synchronous active-low reset
//   rx         : raw serial input (asynchronous, idle high)
//   rx_byte    : received byte, valid while rx_done is high
//   rx_done    : one-cycle pulse in the stop-bit sample cycle, stop bit good
//   rx_frm_err : one-cycle pulse in the stop-bit sample cycle, stop bit low
// ---------------------------------------------------------------------------
module uart_byte_rx
    import host_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_done,
    output logic                 rx_frm_err
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    // Two-flop synchronizer plus one history flop for falling-edge detect.
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

    rx_state_t            state_reg, state_next;
    logic [BAUD_W-1:0]    baud_cnt_reg, baud_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            state_reg    <= RX_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            rx_meta_reg  <= rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        rx_done       = 1'b0;
        rx_frm_err    = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    state_next    = RX_START;
                    baud_cnt_next = '0;
                end
            end
            RX_START: begin
                // Re-check the line half a bit in; a high line means a glitch.
                if (baud_cnt_reg == HALF_LAST) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            RX_DATA: begin
                if (baud_cnt_reg == BIT_LAST) begin
                    baud_cnt_next = '0;
                    shift_next    = {rx_sync_reg, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            RX_STOP: begin
                if (baud_cnt_reg == BIT_LAST) begin
                    baud_cnt_next = '0;
                    state_next    = RX_IDLE;
                    if (rx_sync_reg) begin
                        rx_done = 1'b1;
                    end else begin
                        rx_frm_err = 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_byte = shift_reg;

endmodule

// File: rtl/host_cmd_link.sv
// ---------------------------------------------------------------------------
// host_cmd_link
// Host-facing UART end of the core command/response path (8N1, LSB first).
//   clk, rst_n : system clock, synchronous active-low reset
//   RX         : serial input from host (asynchronous, idle high)
//   TX         : serial output to host (idle high)
//   bus        : core-side command/response bundle (slave side)
// Received bytes are packed MSB-byte-first into a 24-bit command; a partial
// command is abandoned after IDLE_TO clocks without a completed byte. The
// response transmitter runs independently of the receiver.
// ---------------------------------------------------------------------------
module host_cmd_link
    import host_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int IDLE_TO      = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RX,
    output logic             TX,
    host_cmd_link_if.slave   bus
);

    localparam int CNT_W  = $clog2(CMD_BYTES);
    localparam int IDLE_W = $clog2(IDLE_TO + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(CMD_BYTES - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);

    // ---------------- receive side and command assembly ----------------
    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_done, rx_frm_err;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (RX),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .rx_frm_err (rx_frm_err)
    );

    logic [DATA_BITS-1:0] cmd_byte_reg [CMD_BYTES];
    logic [CNT_W-1:0]     byte_cnt_reg;
    logic [IDLE_W-1:0]    idle_cnt_reg;
    logic                 cmd_rdy_reg, frm_err_reg, ovr_err_reg;
    logic [CMD_BYTES-1:0] slice_wr;
    logic [CMD_W-1:0]     cmd_flat;
    logic                 byte_wr, idle_expired;

    // Bytes arriving while a command is pending are dropped, not queued.
    assign byte_wr      = rx_done && !cmd_rdy_reg;
    assign idle_expired = (byte_cnt_reg != '0) && (idle_cnt_reg == IDLE_W'(IDLE_TO));

    genvar gi;
    generate
        for (gi = 0; gi < CMD_BYTES; gi++) begin : g_slice
            assign slice_wr[gi] = byte_wr && (byte_cnt_reg == CNT_W'(gi));
            assign cmd_flat[CMD_W-1-gi*DATA_BITS -: DATA_BITS] = cmd_byte_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CMD_BYTES; i++) begin
                cmd_byte_reg[i] <= '0;
            end
            byte_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            cmd_rdy_reg  <= 1'b0;
            frm_err_reg  <= 1'b0;
            ovr_err_reg  <= 1'b0;
        end else begin
            frm_err_reg <= rx_frm_err;
            ovr_err_reg <= rx_done && cmd_rdy_reg;

            for (int i = 0; i < CMD_BYTES; i++) begin
                if (slice_wr[i]) begin
                    cmd_byte_reg[i] <= rx_byte;
                end
            end

            if (byte_wr) begin
                byte_cnt_reg <= (byte_cnt_reg == LAST_BYTE) ? '0 : byte_cnt_reg + CNT_W'(1);
            end else if (rx_frm_err || idle_expired) begin
                byte_cnt_reg <= '0;
            end

            // The timer only runs while a command is partially assembled.
            if (rx_done || byte_cnt_reg == '0) begin
                idle_cnt_reg <= '0;
            end else if (idle_cnt_reg != IDLE_W'(IDLE_TO)) begin
                idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
            end

            // A completing command beats a simultaneous clear.
            if (byte_wr && byte_cnt_reg == LAST_BYTE) begin
                cmd_rdy_reg <= 1'b1;
            end else if (bus.clr_cmd_rdy) begin
                cmd_rdy_reg <= 1'b0;
            end
        end
    end

    // ---------------- transmit side ----------------
    tx_state_t            tx_state_reg, tx_state_next;
    logic [BAUD_W-1:0]    tx_baud_reg, tx_baud_next;
    logic [BIT_W-1:0]     tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_reg, tx_next;
    logic                 resp_sent_reg, resp_sent_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_reg  <= TX_IDLE;
            tx_baud_reg   <= '0;
            tx_bit_reg    <= '0;
            tx_shift_reg  <= '0;
            tx_reg        <= 1'b1;
            resp_sent_reg <= 1'b0;
        end else begin
            tx_state_reg  <= tx_state_next;
            tx_baud_reg   <= tx_baud_next;
            tx_bit_reg    <= tx_bit_next;
            tx_shift_reg  <= tx_shift_next;
            tx_reg        <= tx_next;
            resp_sent_reg <= resp_sent_next;
        end
    end

    // TX is registered: each branch sets the line level for the next bit.
    always_comb begin
        tx_state_next  = tx_state_reg;
        tx_baud_next   = tx_baud_reg;
        tx_bit_next    = tx_bit_reg;
        tx_shift_next  = tx_shift_reg;
        tx_next        = tx_reg;
        resp_sent_next = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_next = 1'b1;
                if (bus.send_resp) begin
                    tx_shift_next = bus.resp_data;
                    tx_baud_next  = '0;
                    tx_state_next = TX_START;
                    tx_next       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_baud_reg == BIT_LAST) begin
                    tx_baud_next  = '0;
                    tx_bit_next   = '0;
                    tx_state_next = TX_DATA;
                    tx_next       = tx_shift_reg[0];
                end else begin
                    tx_baud_next = tx_baud_reg + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_baud_reg == BIT_LAST) begin
                    tx_baud_next = '0;
                    if (tx_bit_reg == BIT_W'(DATA_BITS - 1)) begin
                        tx_state_next = TX_STOP;
                        tx_next       = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + BIT_W'(1);
                        tx_shift_next = {1'b0, tx_shift_reg[DATA_BITS-1:1]};
                        tx_next       = tx_shift_reg[1];
                    end
                end else begin
                    tx_baud_next = tx_baud_reg + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_baud_reg == BIT_LAST) begin
                    tx_baud_next   = '0;
                    tx_state_next  = TX_IDLE;
                    tx_next        = 1'b1;
                    resp_sent_next = 1'b1;
                end else begin
                    tx_baud_next = tx_baud_reg + BAUD_W'(1);
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign TX            = tx_reg;
    assign bus.cmd       = cmd_flat;
    assign bus.cmd_rdy   = cmd_rdy_reg;
    assign bus.resp_sent = resp_sent_reg;
    assign bus.frm_err   = frm_err_reg;
    assign bus.ovr_err   = ovr_err_reg;

endmodule

// File: tb/tb_host_cmd_link.sv
`timescale 1ns/1ps
module tb_host_cmd_link;
    import host_link_pkg::*;

    localparam int CPB  = 16;
    localparam int IDLE = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic RX    = 1'b1;
    logic TX;

    host_cmd_link_if bus();

    host_cmd_link #(.CLKS_PER_BIT(CPB), .IDLE_TO(IDLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int frm_cnt     = 0;
    int ovr_cnt     = 0;
    int sent_cnt    = 0;

    always @(posedge clk) begin
        if (bus.frm_err === 1'b1)   frm_cnt  <= frm_cnt + 1;
        if (bus.ovr_err === 1'b1)   ovr_cnt  <= ovr_cnt + 1;
        if (bus.resp_sent === 1'b1) sent_cnt <= sent_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Start bit plus 8 data bits, LSB first; returns at the stop-bit start.
    task automatic send_head(input logic [7:0] b);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        $display("host byte %02h stop=%0b", b, stop_bit);
        send_head(b);
        RX = stop_bit;
        repeat (CPB) @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (TX !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", TX); end
        vectors++;
        if (bus.cmd !== 24'h0) begin miscompares++; $display("FAIL reset_cmd: got %h want 000000", bus.cmd); end
        vectors++;
        if ({bus.cmd_rdy, bus.resp_sent, bus.frm_err, bus.ovr_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy/sent/frm/ovr=%b want 0000",
                     {bus.cmd_rdy, bus.resp_sent, bus.frm_err, bus.ovr_err});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_cmd_basic();
        send_byte(8'h05, 1'b1);
        send_byte(8'hA3, 1'b1);
        $display("host byte 7c stop=1 (timed)");
        send_head(8'h7C);
        RX = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL basic_rdy_early: got %b want 0", bus.cmd_rdy); end
        @(negedge clk);
        vectors++;
        if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL basic_rdy_set: got %b want 1", bus.cmd_rdy); end
        vectors++;
        if (bus.cmd !== 24'h05A37C) begin miscompares++; $display("FAIL basic_cmd: got %h want 05a37c", bus.cmd); end
        repeat (5) @(negedge clk);
        pulse_clr();
        vectors++;
        if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL basic_clr: got %b want 0", bus.cmd_rdy); end
        vectors++;
        if (bus.cmd !== 24'h05A37C) begin miscompares++; $display("FAIL basic_cmd_kept: got %h want 05a37c", bus.cmd); end
        $display("test_cmd_basic done");
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame;
        int sent0;
        frame = {1'b1, 8'hA5, 1'b0};
        sent0 = sent_cnt;
        bus.resp_data = 8'hA5;
        bus.send_resp = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1)  bus.send_resp = 1'b0;
            if (k == 40) begin bus.resp_data = 8'h00; bus.send_resp = 1'b1; end
            if (k == 41) bus.send_resp = 1'b0;
            if (k <= 10 * CPB && ((k - 1) % CPB == 0 || (k - 1) % CPB == CPB - 1)) begin
                vectors++;
                if (TX !== frame[(k - 1) / CPB]) begin
                    miscompares++;
                    $display("FAIL tx_bit%0d_k%0d: got %b want %b", (k - 1) / CPB, k, TX, frame[(k - 1) / CPB]);
                end
            end
            if (k == 160 || k == 161) begin
                vectors++;
                if (bus.resp_sent !== (k == 161)) begin
                    miscompares++;
                    $display("FAIL tx_resp_sent_k%0d: got %b want %b", k, bus.resp_sent, (k == 161));
                end
            end
        end
        vectors++;
        if (TX !== 1'b1) begin miscompares++; $display("FAIL tx_idle_after: got %b want 1", TX); end
        vectors++;
        if (sent_cnt - sent0 !== 1) begin miscompares++; $display("FAIL tx_sent_count: got %0d want 1", sent_cnt - sent0); end
        $display("test_tx_frame done");
    endtask

    task automatic test_idle_timeout();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (IDLE) @(negedge clk);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        vectors++;
        if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL timeout_rdy: got %b want 1", bus.cmd_rdy); end
        vectors++;
        if (bus.cmd !== 24'h334455) begin miscompares++; $display("FAIL timeout_cmd: got %h want 334455", bus.cmd); end
        pulse_clr();
        $display("test_idle_timeout done");
    endtask

    task automatic test_frame_error();
        int frm0;
        frm0 = frm_cnt;
        send_byte(8'h66, 1'b0);
        vectors++;
        if (frm_cnt - frm0 !== 1) begin miscompares++; $display("FAIL frm_pulse: got %0d pulses want 1", frm_cnt - frm0); end
        vectors++;
        if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL frm_rdy: got %b want 0", bus.cmd_rdy); end
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        vectors++;
        if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL frm_next_rdy: got %b want 1", bus.cmd_rdy); end
        vectors++;
        if (bus.cmd !== 24'h010203) begin miscompares++; $display("FAIL frm_next_cmd: got %h want 010203", bus.cmd); end
        pulse_clr();
        $display("test_frame_error done");
    endtask

    task automatic test_overrun();
        int ovr0;
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        vectors++;
        if (bus.cmd !== 24'hDEADBE) begin miscompares++; $display("FAIL ovr_setup_cmd: got %h want deadbe", bus.cmd); end
        ovr0 = ovr_cnt;
        send_byte(8'h99, 1'b1);
        vectors++;
        if (ovr_cnt - ovr0 !== 1) begin miscompares++; $display("FAIL ovr_pulse: got %0d pulses want 1", ovr_cnt - ovr0); end
        vectors++;
        if (bus.cmd !== 24'hDEADBE) begin miscompares++; $display("FAIL ovr_cmd_held: got %h want deadbe", bus.cmd); end
        vectors++;
        if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL ovr_rdy_held: got %b want 1", bus.cmd_rdy); end
        pulse_clr();
        vectors++;
        if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL ovr_clr: got %b want 0", bus.cmd_rdy); end
        send_byte(8'hCA, 1'b1);
        send_byte(8'hFE, 1'b1);
        fork
            send_byte(8'h42, 1'b1);
            begin
                repeat (154) @(negedge clk);
                bus.clr_cmd_rdy = 1'b1;
                @(negedge clk);
                bus.clr_cmd_rdy = 1'b0;
            end
        join
        vectors++;
        if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL set_beats_clr: got %b want 1", bus.cmd_rdy); end
        vectors++;
        if (bus.cmd !== 24'hCAFE42) begin miscompares++; $display("FAIL set_beats_clr_cmd: got %h want cafe42", bus.cmd); end
        $display("test_overrun done");
    endtask

    task automatic test_reset_mid_frame();
        int sent0;
        sent0 = sent_cnt;
        bus.resp_data = 8'h0F;
        bus.send_resp = 1'b1;
        fork
            send_byte(8'hF0, 1'b1);
            begin
                @(negedge clk);
                bus.send_resp = 1'b0;
                repeat (87) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                vectors++;
                if (TX !== 1'b1) begin miscompares++; $display("FAIL midrst_tx: got %b want 1", TX); end
                vectors++;
                if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL midrst_rdy: got %b want 0", bus.cmd_rdy); end
                vectors++;
                if (bus.cmd !== 24'h0) begin miscompares++; $display("FAIL midrst_cmd: got %h want 000000", bus.cmd); end
            end
        join
        repeat (200) @(negedge clk);
        vectors++;
        if (sent_cnt - sent0 !== 0) begin miscompares++; $display("FAIL midrst_no_sent: got %0d pulses want 0", sent_cnt - sent0); end
        vectors++;
        if (TX !== 1'b1) begin miscompares++; $display("FAIL midrst_tx_idle: got %b want 1", TX); end
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        vectors++;
        if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL midrst_after_rdy: got %b want 1", bus.cmd_rdy); end
        vectors++;
        if (bus.cmd !== 24'h123456) begin miscompares++; $display("FAIL midrst_after_cmd: got %h want 123456", bus.cmd); end
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        bus.clr_cmd_rdy = 1'b0;
        bus.resp_data   = 8'h00;
        bus.send_resp   = 1'b0;
        @(negedge clk);
        test_reset();
        test_cmd_basic();
        test_tx_frame();
        test_idle_timeout();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
